// File: rtl/boot_pkg.sv
// Shared types and constants for the serial boot loader and its UART receiver.
package boot_pkg;

    localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'hA5;
    localparam int BYTE_W = 8;
    localparam int WORD_W = 16;
    localparam int LEN_W  = 16;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LEN_HI,
        ST_LEN_LO,
        ST_DATA_HI,
        ST_DATA_LO,
        ST_CHK,
        ST_DONE,
        ST_ERROR
    } loader_state_t;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_t;

endpackage

// File: rtl/uart_rx.sv
// 8N1 receiver: 2-flop synchronizer, start-bit glitch reject, mid-bit sampling.
module uart_rx import boot_pkg::*; #(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rx,
    output logic              byte_valid,
    output logic [BYTE_W-1:0] byte_data,
    output logic              frame_err
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);

    rx_state_t        state;
    logic             rx_meta;
    logic             rx_sync;
    logic             rx_prev;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       bit_idx;

    always_ff @(posedge clk) begin
        if (reset) begin
            rx_meta    <= 1'b1;
            rx_sync    <= 1'b1;
            rx_prev    <= 1'b1;
            state      <= RX_IDLE;
            cnt        <= '0;
            bit_idx    <= '0;
            byte_data  <= '0;
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments make every flop take its pre-edge value; blocking would collapse the synchronizer chain.
            rx_meta    <= rx;
            rx_sync    <= rx_meta;
            rx_prev    <= rx_sync;
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
            case (state)
                RX_IDLE: begin
                    // Edge rather than level, so a low line left by a bad stop bit does not re-trigger.
                    if (rx_prev && !rx_sync) begin
                        state <= RX_START;
                        cnt   <= '0;
                    end
                end
                RX_START: begin
                    if (cnt == HALF_LAST) begin
                        cnt     <= '0;
                        bit_idx <= '0;
                        state   <= rx_sync ? RX_IDLE : RX_DATA;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                RX_DATA: begin
                    if (cnt == BIT_LAST) begin
                        cnt       <= '0;
                        byte_data <= {rx_sync, byte_data[BYTE_W-1:1]};
                        bit_idx   <= bit_idx + 3'd1;
                        if (bit_idx == 3'd7) state <= RX_STOP;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                RX_STOP: begin
                    if (cnt == BIT_LAST) begin
                        cnt   <= '0;
                        state <= RX_IDLE;
                        if (rx_sync) byte_valid <= 1'b1;
                        else         frame_err  <= 1'b1;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: state <= RX_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/serial_boot_loader.sv
// Loads a framed program image from a serial line into instruction memory, then pulses start.
// Define BOOT_CHECKSUM_EN to require a trailing XOR checksum byte.
module serial_boot_loader import boot_pkg::*; #(
    parameter int          CLKS_PER_BIT = 434,
    parameter int          ADDR_W       = 13,
    parameter logic [7:0]  SYNC_BYTE    = DEFAULT_SYNC_BYTE
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rx,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [WORD_W-1:0] imem_data,
    output logic              imem_we,
    output logic              start,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam logic [LEN_W:0] MAX_LEN = {{LEN_W{1'b0}}, 1'b1} << ADDR_W;

    logic              byte_valid;
    logic [BYTE_W-1:0] byte_data;
    logic              frame_err;

    uart_rx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
        .clk        (clk),
        .reset      (reset),
        .rx         (rx),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .frame_err  (frame_err)
    );

    loader_state_t     state;
    logic [BYTE_W-1:0] len_hi;
    logic [BYTE_W-1:0] hi_byte;
    logic [LEN_W-1:0]  words_left;
    logic              launch;
`ifdef BOOT_CHECKSUM_EN
    logic [BYTE_W-1:0] chk;
`endif

    logic [LEN_W-1:0] len_word;
    logic             len_bad;
    assign len_word = {len_hi, byte_data};
    assign len_bad  = (len_word == '0) || ({1'b0, len_word} > MAX_LEN);

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_IDLE;
            imem_addr  <= '0;
            imem_data  <= '0;
            imem_we    <= 1'b0;
            start      <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
            len_hi     <= '0;
            hi_byte    <= '0;
            words_left <= '0;
            launch     <= 1'b0;
`ifdef BOOT_CHECKSUM_EN
            chk        <= '0;
`endif
        end else begin
            imem_we <= 1'b0;
            start   <= 1'b0;
            launch  <= 1'b0;
            // Address moves on the cycle after the strobe so it is stable while imem_we is high.
            if (imem_we) imem_addr <= imem_addr + ADDR_W'(1);
            if (launch) begin
                start <= 1'b1;
                done  <= 1'b1;
            end

            if (frame_err && busy) begin
                state <= ST_ERROR;
                busy  <= 1'b0;
                err   <= 1'b1;
            end else if (byte_valid) begin
                case (state)
                    ST_IDLE, ST_DONE: begin
                        if (byte_data == SYNC_BYTE) begin
                            state <= ST_LEN_HI;
                            busy  <= 1'b1;
                            done  <= 1'b0;
`ifdef BOOT_CHECKSUM_EN
                            chk   <= '0;
`endif
                        end
                    end
                    ST_LEN_HI: begin
                        len_hi <= byte_data;
                        state  <= ST_LEN_LO;
`ifdef BOOT_CHECKSUM_EN
                        chk    <= chk ^ byte_data;
`endif
                    end
                    ST_LEN_LO: begin
`ifdef BOOT_CHECKSUM_EN
                        chk <= chk ^ byte_data;
`endif
                        if (len_bad) begin
                            state <= ST_ERROR;
                            busy  <= 1'b0;
                            err   <= 1'b1;
                        end else begin
                            words_left <= len_word;
                            imem_addr  <= '0;
                            state      <= ST_DATA_HI;
                        end
                    end
                    ST_DATA_HI: begin
                        hi_byte <= byte_data;
                        state   <= ST_DATA_LO;
`ifdef BOOT_CHECKSUM_EN
                        chk     <= chk ^ byte_data;
`endif
                    end
                    ST_DATA_LO: begin
                        imem_data  <= {hi_byte, byte_data};
                        imem_we    <= 1'b1;
                        words_left <= words_left - LEN_W'(1);
`ifdef BOOT_CHECKSUM_EN
                        chk        <= chk ^ byte_data;
                        state      <= (words_left == LEN_W'(1)) ? ST_CHK : ST_DATA_HI;
`else
                        // start/done follow one cycle later, right after the final strobe.
                        if (words_left == LEN_W'(1)) begin
                            state  <= ST_DONE;
                            busy   <= 1'b0;
                            launch <= 1'b1;
                        end else begin
                            state <= ST_DATA_HI;
                        end
`endif
                    end
`ifdef BOOT_CHECKSUM_EN
                    ST_CHK: begin
                        busy <= 1'b0;
                        if (byte_data == chk) begin
                            state <= ST_DONE;
                            start <= 1'b1;
                            done  <= 1'b1;
                        end else begin
                            state <= ST_ERROR;
                            err   <= 1'b1;
                        end
                    end
`endif
                    default: ;
                endcase
            end
        end
    end

endmodule
